// File: rtl/key_filter_pkg.sv
// Shared definitions for the key filter: per-channel state encoding and counter sizing.
package key_filter_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      P_FILTER = 2'd1,
      HELD     = 2'd2,
      R_FILTER = 2'd3
   } key_state_e;

   // One width covers debounce, hold and repeat counters so they can be compared uniformly.
   function automatic int unsigned cnt_width(input int unsigned deb,
                                             input int unsigned lng,
                                             input int unsigned rpt);
      int unsigned m;
      m = deb;
      if (lng > m) m = lng;
      if (rpt > m) m = rpt;
      return unsigned'($clog2(m + 1));
   endfunction

endpackage

// File: rtl/key_filter_ch.sv
// One key channel: 2-flop synchroniser, history flop, debounce FSM, long-press and
// optional auto-repeat (built only when KEY_REPEAT_EN is defined).
module key_filter_ch
   import key_filter_pkg::*;
#(
   parameter int unsigned ACTIVE_LOW   = 1,
   parameter int unsigned DEBOUNCE_CNT = 1_000_000,
   parameter int unsigned LONG_CNT     = 50_000_000,
   parameter int unsigned REPEAT_CNT   = 10_000_000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_key,
   output logic o_p_flag,
   output logic o_r_flag,
   output logic o_l_flag,
   output logic o_rpt_flag,
   output logic o_state
);

   localparam int unsigned CW = cnt_width(DEBOUNCE_CNT, LONG_CNT, REPEAT_CNT);

   logic          w_key_norm;
   logic          r_sync1, r_sync2, r_hist;
   logic          w_press_edge, w_release_edge;
   key_state_e    r_state, w_state_nxt;
   logic [CW-1:0] r_deb_cnt, w_deb_nxt;
   logic [CW-1:0] r_hold_cnt, w_hold_nxt;
   logic          r_p_flag, w_p_nxt;
   logic          r_r_flag, w_r_nxt;
   logic          r_l_flag, w_l_nxt;
   logic          r_level, w_level_nxt;

   // Normalise to 1 = pressed ahead of the synchroniser so reset loads "released".
   assign w_key_norm = (ACTIVE_LOW != 0) ? ~i_key : i_key;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_hist  <= 1'b0;
      end else begin
         r_sync1 <= w_key_norm;
         r_sync2 <= r_sync1;
         r_hist  <= r_sync2;
      end
   end

   assign w_press_edge   = r_sync2 & ~r_hist;
   assign w_release_edge = ~r_sync2 & r_hist;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= IDLE;
         r_deb_cnt  <= '0;
         r_hold_cnt <= '0;
         r_p_flag   <= 1'b0;
         r_r_flag   <= 1'b0;
         r_l_flag   <= 1'b0;
         r_level    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_deb_cnt  <= w_deb_nxt;
         r_hold_cnt <= w_hold_nxt;
         r_p_flag   <= w_p_nxt;
         r_r_flag   <= w_r_nxt;
         r_l_flag   <= w_l_nxt;
         r_level    <= w_level_nxt;
      end
   end

   // Hold counter runs on every HELD cycle, including the one that leaves for R_FILTER,
   // so a release bounce delays the long press by exactly the cycles spent filtering.
   always_comb begin
      w_state_nxt = r_state;
      w_deb_nxt   = r_deb_cnt;
      w_hold_nxt  = r_hold_cnt;
      w_p_nxt     = 1'b0;
      w_r_nxt     = 1'b0;
      w_l_nxt     = 1'b0;
      w_level_nxt = r_level;
      case (r_state)
         IDLE: begin
            w_deb_nxt = '0;
            if (w_press_edge) w_state_nxt = P_FILTER;
         end
         P_FILTER: begin
            if (w_release_edge) begin
               w_state_nxt = IDLE;
               w_deb_nxt   = '0;
            end else if (r_deb_cnt == CW'(DEBOUNCE_CNT)) begin
               w_state_nxt = HELD;
               w_deb_nxt   = '0;
               w_p_nxt     = 1'b1;
               w_level_nxt = 1'b1;
            end else begin
               w_deb_nxt = r_deb_cnt + CW'(1);
            end
         end
         HELD: begin
            w_deb_nxt = '0;
            if (r_hold_cnt < CW'(LONG_CNT)) begin
               w_hold_nxt = r_hold_cnt + CW'(1);
               if (r_hold_cnt == CW'(LONG_CNT - 1)) w_l_nxt = 1'b1;
            end
            if (w_release_edge) w_state_nxt = R_FILTER;
         end
         R_FILTER: begin
            if (w_press_edge) begin
               w_state_nxt = HELD;
               w_deb_nxt   = '0;
            end else if (r_deb_cnt == CW'(DEBOUNCE_CNT)) begin
               w_state_nxt = IDLE;
               w_deb_nxt   = '0;
               w_hold_nxt  = '0;
               w_r_nxt     = 1'b1;
               w_level_nxt = 1'b0;
            end else begin
               w_deb_nxt = r_deb_cnt + CW'(1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

`ifdef KEY_REPEAT_EN
   logic [CW-1:0] r_rpt_cnt, w_rpt_nxt;
   logic          r_rpt_flag, w_rpt_flag_nxt;

   // Repeat counter only runs once the hold counter has saturated, so it never
   // fires in the same cycle as the long-press pulse.
   always_comb begin
      w_rpt_nxt      = r_rpt_cnt;
      w_rpt_flag_nxt = 1'b0;
      if (r_state == HELD && r_hold_cnt == CW'(LONG_CNT)) begin
         if (r_rpt_cnt == CW'(REPEAT_CNT - 1)) begin
            w_rpt_nxt      = '0;
            w_rpt_flag_nxt = 1'b1;
         end else begin
            w_rpt_nxt = r_rpt_cnt + CW'(1);
         end
      end else if (r_state == IDLE) begin
         w_rpt_nxt = '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rpt_cnt  <= '0;
         r_rpt_flag <= 1'b0;
      end else begin
         r_rpt_cnt  <= w_rpt_nxt;
         r_rpt_flag <= w_rpt_flag_nxt;
      end
   end

   assign o_rpt_flag = r_rpt_flag;
`else
   assign o_rpt_flag = 1'b0;
`endif

   assign o_p_flag = r_p_flag;
   assign o_r_flag = r_r_flag;
   assign o_l_flag = r_l_flag;
   assign o_state  = r_level;

endmodule

// File: rtl/multi_key_filter.sv
// NUM_KEYS independent push-button conditioners; auto-repeat built when KEY_REPEAT_EN is defined.
module multi_key_filter
   import key_filter_pkg::*;
#(
   parameter int unsigned NUM_KEYS     = 4,
   parameter int unsigned ACTIVE_LOW   = 1,
   parameter int unsigned DEBOUNCE_CNT = 1_000_000,
   parameter int unsigned LONG_CNT     = 50_000_000,
   parameter int unsigned REPEAT_CNT   = 10_000_000
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic [NUM_KEYS-1:0] Key,
   output logic [NUM_KEYS-1:0] Key_P_flag,
   output logic [NUM_KEYS-1:0] Key_R_flag,
   output logic [NUM_KEYS-1:0] Key_L_flag,
   output logic [NUM_KEYS-1:0] Key_Rpt_flag,
   output logic [NUM_KEYS-1:0] Key_state
);

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
      key_filter_ch #(
         .ACTIVE_LOW   (ACTIVE_LOW),
         .DEBOUNCE_CNT (DEBOUNCE_CNT),
         .LONG_CNT     (LONG_CNT),
         .REPEAT_CNT   (REPEAT_CNT)
      ) u_ch (
         .i_clk      (Clk),
         .i_rst      (Reset),
         .i_key      (Key[g]),
         .o_p_flag   (Key_P_flag[g]),
         .o_r_flag   (Key_R_flag[g]),
         .o_l_flag   (Key_L_flag[g]),
         .o_rpt_flag (Key_Rpt_flag[g]),
         .o_state    (Key_state[g])
      );
   end

endmodule

// File: doc/multi_key_filter.md
# multi_key_filter

Parametrised N-channel push-button conditioner: synchronises, debounces, and edge-flags NUM_KEYS raw key inputs, and adds long-press and auto-repeat detection per key. It sits between the board buttons and the clock's mode/set control logic. Each channel is an independent debounce state machine. Channels share only clock, reset and parameters.

## Interface
- NUM_KEYS, 4: number of independent key channels.
- ACTIVE_LOW, 1: 1 means a key reads 0 when pressed; 0 means it reads 1 when pressed.
- DEBOUNCE_CNT, 1_000_000: filter window in cycles (20 ms at 50 MHz); must be ≥1.
- LONG_CNT, 50_000_000: debounced hold time in cycles before the long-press flag fires; must be > DEBOUNCE_CNT.
- REPEAT_CNT, 10_000_000: auto-repeat period in cycles after a long press; must be ≥1.
- Clk  in  1  system clock; all logic is on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Key  in  NUM_KEYS  raw asynchronous key inputs.
- Key_P_flag  out  NUM_KEYS  one-cycle pulse per confirmed press.
- Key_R_flag  out  NUM_KEYS  one-cycle pulse per confirmed release.
- Key_L_flag  out  NUM_KEYS  one-cycle pulse when a hold reaches LONG_CNT.
- Key_Rpt_flag  out  NUM_KEYS  one-cycle pulse every REPEAT_CNT cycles after the long press.
- Key_state  out  NUM_KEYS  debounced level; 1 means pressed, regardless of ACTIVE_LOW.

## Operation
- Input conditioning, per channel:
  - Two-flop synchroniser, then one history register.
  - Press edge: the synchronised level changes from released to pressed. Release edge is the reverse.
  - Polarity is normalised by ACTIVE_LOW before edge detection.
- States: IDLE, P_FILTER, HELD, R_FILTER (encoding in package).
  - IDLE: on press edge, go to P_FILTER.
  - P_FILTER: debounce counter runs from 0.
    - A release edge before the count reaches DEBOUNCE_CNT returns to IDLE with no flag.
    - Otherwise, at the count: pulse Key_P_flag, set Key_state=1, go to HELD.
  - HELD: the hold counter increments each cycle.
    - A release edge goes to R_FILTER. The hold counter freezes; it is not cleared.
  - R_FILTER: debounce counter runs from 0.
    - A press edge before DEBOUNCE_CNT returns to HELD; the hold counter resumes.
    - Otherwise, at the count: pulse Key_R_flag, clear Key_state, clear the hold counter, go to IDLE.
- Debounce counter is cleared in every cycle the channel is in IDLE or HELD.
- Long press: when the hold counter reaches LONG_CNT in HELD, pulse Key_L_flag once per press.
- Auto-repeat (macro-enabled):
  - After Key_L_flag, the repeat counter pulses Key_Rpt_flag every REPEAT_CNT cycles while in HELD.
  - The first repeat pulse comes REPEAT_CNT cycles after Key_L_flag.
  - The repeat counter freezes in R_FILTER.
- Counter width: $clog2(max(DEBOUNCE_CNT, LONG_CNT, REPEAT_CNT)+1). The hold counter saturates at LONG_CNT.
- A release after a long press still produces Key_R_flag.
- Channels are fully independent. Any combination of flags across channels may assert in the same cycle.
- On a single channel, Key_L_flag and Key_Rpt_flag never assert in the same cycle.

## Timing
- Reset values:
  - All flags and Key_state are 0.
  - All states are IDLE and all counters are 0.
  - Synchroniser and history registers load the released level. A key held through reset is therefore detected as a fresh press after reset deasserts.
- Press latency: take the input edge that first samples a stable pressed level as edge 0. Key_P_flag is high after edge DEBOUNCE_CNT+3, for exactly one cycle. Release latency is identical.
- Key_L_flag rises LONG_CNT cycles after Key_P_flag, assuming no bounce in between.
- Reset asserted mid-operation: outputs clear immediately (asynchronously) and no partial flags follow. A pending press must be re-filtered from the start.
- All outputs are registered; there is no combinational path from Key to any output.

## Configuration
- KEY_REPEAT_EN defined:
  - Repeat counters and logic are built.
  - Key_Rpt_flag behaves as above.
- KEY_REPEAT_EN undefined:
  - No repeat logic is built.
  - Key_Rpt_flag is tied to 0.
  - Key_L_flag and all other behaviour are unchanged.

## Structure
- Package key_filter_pkg holds:
  - the state encoding (IDLE=0, P_FILTER=1, HELD=2, R_FILTER=3);
  - the counter-width function.
- Sub-module key_filter_ch holds the per-channel synchroniser, FSM and counters. multi_key_filter instantiates it NUM_KEYS times in a generate loop and concatenates the outputs.

## Test plan
Bench parameters: NUM_KEYS=4, DEBOUNCE_CNT=8, LONG_CNT=40, REPEAT_CNT=10, ACTIVE_LOW=1, KEY_REPEAT_EN defined.
- Clean press:
  - Stimulus: Key[0] drops to 0 and stays.
  - Response: Key_P_flag[0] is a single pulse after edge 11 and Key_state[0]=1. No other flags fire.
- Bounce:
  - Stimulus: Key[1] drops for 5 cycles, rises for 3, then drops and holds.
  - Response: exactly one Key_P_flag[1], 11 cycles after the final drop.
- Long press and repeat:
  - Stimulus: hold Key[2] for 100 cycles after Key_P_flag.
  - Response: Key_L_flag at +40, then Key_Rpt_flag at +50, +60, … +100. Release then gives one Key_R_flag.
- Release bounce in HELD:
  - Stimulus: Key[3] rises for 4 cycles, then returns low.
  - Response: no Key_R_flag; the hold count resumes, so Key_L_flag is delayed by exactly the frozen cycles.
- Simultaneous keys:
  - Stimulus: all four keys pressed on the same edge.
  - Response: all four Key_P_flag bits pulse in the same cycle.
- Reset mid-filter, plus a build without KEY_REPEAT_EN:
  - Stimulus: assert Reset during P_FILTER with the key held.
  - Response: outputs go to 0; after deassertion, Key_P_flag arrives 11 cycles later.
  - Without KEY_REPEAT_EN, Key_Rpt_flag stays 0 throughout the long-press scenario.
